// File: rtl/mc_dst_fork.sv
// Multicast destination fork: holds one flit and splits its destination
// list across output ports using allocator grants. Copies are launched
// from registers. MODE 0 puts any ungranted destinations on the
// lowest-index granted copy. MODE 1 keeps ungranted destinations and
// retries them.
//
// Handshake: the input side uses valid/ready. A flit transfers on any
// rising edge where in_valid and in_ready are both high. in_ready does
// not depend on in_valid. It may rise in the release cycle, so a new
// flit can load without a bubble. The allocator side has no
// backpressure: out_valid[p] is a one-cycle pulse for every granted
// port p.
module mc_dst_fork #(
  parameter int NUM_PORT  = 5,
  parameter int FIELD_W   = 4,
  parameter int DATA_W    = 64,
  parameter int MODE      = 0,
  parameter int MAX_RETRY = 15
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_PORT*FIELD_W-1:0]     in_dst,
  input  logic [DATA_W-1:0]               in_data,
  output logic [NUM_PORT-1:0]             req_pv,
  input  logic [NUM_PORT-1:0]             alloc_pv,
  output logic [NUM_PORT-1:0]             out_valid,
  output logic [NUM_PORT*NUM_PORT*FIELD_W-1:0] out_dst,
  output logic [NUM_PORT*DATA_W-1:0]      out_data,
  output logic                            busy,
  output logic                            starve
);

  localparam int DST_W   = NUM_PORT * FIELD_W;
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t               state;
  logic [DST_W-1:0]     residual;
  logic [DATA_W-1:0]    data_q;
  logic [RETRY_W-1:0]   retry;
  logic [RETRY_W-1:0]   retry_next;
  logic [NUM_PORT-1:0]  g;
  logic [NUM_PORT-1:0]  prim;
  logic [DST_W-1:0]     grant_mask;
  logic [DST_W-1:0]     residual_hold_next;
  logic [DST_W-1:0]     copy_dst [NUM_PORT];
  logic                 release_hold;
  logic                 accept;

  function automatic logic [DST_W-1:0] field_mask(input int p);
    field_mask = '0;
    field_mask[p*FIELD_W +: FIELD_W] = '1;
  endfunction

  assign busy = (state == HOLD);

  // Request every port that still owns a nonzero field of the held residual.
  always_comb begin
    req_pv = '0;
    for (int p = 0; p < NUM_PORT; p++) begin
      req_pv[p] = |residual[p*FIELD_W +: FIELD_W];
    end
  end

  // Grants count only for requested ports while a flit is held.
  // prim is the lowest-index granted port, in one-hot form.
  assign g    = busy ? (alloc_pv & req_pv) : '0;
  assign prim = g & (~g + NUM_PORT'(1));

  // Union of the field masks of all granted ports.
  always_comb begin
    grant_mask = '0;
    for (int p = 0; p < NUM_PORT; p++) begin
      if (g[p]) grant_mask = grant_mask | field_mask(p);
    end
  end

  // Destination subset for each port's copy. In MODE 0 the primary copy
  // carries everything that no other granted port takes.
  always_comb begin
    for (int p = 0; p < NUM_PORT; p++) begin
      copy_dst[p] = residual & field_mask(p);
      if (MODE == 0 && prim[p]) begin
        copy_dst[p] = residual & ~(grant_mask & ~field_mask(p));
      end
    end
  end

  // Residual after this hold cycle, and the release decision.
  always_comb begin
    if (MODE == 1) begin
      residual_hold_next = residual & ~grant_mask;
      release_hold       = busy && (residual_hold_next == '0);
    end else begin
      residual_hold_next = (g != '0) ? '0 : residual;
      release_hold       = busy && (g != '0);
    end
  end

  assign in_ready = !busy || release_hold;
  assign accept   = in_valid && in_ready;

  // Retry counter: cleared on load or on any grant; saturates on zero-grant cycles.
  always_comb begin
    retry_next = retry;
    if (accept && (in_dst != '0)) begin
      retry_next = '0;
    end else if (busy) begin
      if (g != '0)                               retry_next = '0;
      else if (retry != RETRY_W'(MAX_RETRY))     retry_next = retry + RETRY_W'(1);
    end
  end

  // Control FSM: load, hold, release; registered starve flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      residual <= '0;
      data_q   <= '0;
      retry    <= '0;
      starve   <= 1'b0;
    end else begin
      if (accept) begin
        if (in_dst != '0) begin
          state    <= HOLD;
          residual <= in_dst;
          data_q   <= in_data;
        end else begin
          state    <= IDLE;
          residual <= '0;
        end
      end else if (busy) begin
        residual <= residual_hold_next;
        if (release_hold) state <= IDLE;
      end
      retry  <= retry_next;
      starve <= (retry_next == RETRY_W'(MAX_RETRY));
    end
  end

  // Launch registered copies on granted ports. Slices of idle ports keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_dst   <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= g;
      for (int p = 0; p < NUM_PORT; p++) begin
        if (g[p]) begin
          out_dst[p*DST_W +: DST_W]    <= copy_dst[p];
          out_data[p*DATA_W +: DATA_W] <= data_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_mc_dst_fork.sv
// Bench for mc_dst_fork. There are two instances: MODE 0 and MODE 1, both
// with MAX_RETRY = 3. Directed vectors push hand-computed copies into a
// per-instance expected queue. A monitor pops the queue and compares on
// every out_valid pulse.
module tb_mc_dst_fork;

  localparam int NP = 5;
  localparam int FW = 4;
  localparam int DW = 64;
  localparam int SW = NP * FW;
  localparam int EW = 3 + SW + DW;

  logic clk;
  logic rst_n;

  logic            v0, v1;
  logic            rdy0, rdy1;
  logic [SW-1:0]   dst0, dst1;
  logic [DW-1:0]   dat0, dat1;
  logic [NP-1:0]   req0, req1;
  logic [NP-1:0]   al0, al1;
  logic [NP-1:0]   ov0, ov1;
  logic [NP*SW-1:0] od0, od1;
  logic [NP*DW-1:0] odat0, odat1;
  logic            busy0, busy1;
  logic            stv0, stv1;

  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];

  int n_vec  = 0;
  int n_fail = 0;

  mc_dst_fork #(.NUM_PORT(NP), .FIELD_W(FW), .DATA_W(DW), .MODE(0), .MAX_RETRY(3)) u_m0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .in_dst(dst0),
    .in_data(dat0), .req_pv(req0), .alloc_pv(al0), .out_valid(ov0), .out_dst(od0),
    .out_data(odat0), .busy(busy0), .starve(stv0)
  );

  mc_dst_fork #(.NUM_PORT(NP), .FIELD_W(FW), .DATA_W(DW), .MODE(1), .MAX_RETRY(3)) u_m1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_dst(dst1),
    .in_data(dat1), .req_pv(req1), .alloc_pv(al1), .out_valid(ov1), .out_dst(od1),
    .out_data(odat1), .busy(busy1), .starve(stv1)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Driver and check tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push0(input int p, input logic [SW-1:0] d, input logic [DW-1:0] x);
    exp_q0.push_back({3'(p), d, x});
  endtask

  task automatic push1(input int p, input logic [SW-1:0] d, input logic [DW-1:0] x);
    exp_q1.push_back({3'(p), d, x});
  endtask

  // Scoreboard monitors: compare every launched copy against the queue head.
  always @(negedge clk) begin
    logic [EW-1:0] act, e;
    if (rst_n) begin
      for (int p = 0; p < NP; p++) begin
        if (ov0[p]) begin
          act = {3'(p), od0[p*SW +: SW], odat0[p*DW +: DW]};
          n_vec++;
          if (exp_q0.size() == 0) begin
            n_fail++;
            $display("FAIL m0_unexpected_copy: got %h expected none", act);
          end else begin
            e = exp_q0.pop_front();
            if (act !== e) begin
              n_fail++;
              $display("FAIL m0_copy: got %h expected %h", act, e);
            end
          end
        end
        if (ov1[p]) begin
          act = {3'(p), od1[p*SW +: SW], odat1[p*DW +: DW]};
          n_vec++;
          if (exp_q1.size() == 0) begin
            n_fail++;
            $display("FAIL m1_unexpected_copy: got %h expected none", act);
          end else begin
            e = exp_q1.pop_front();
            if (act !== e) begin
              n_fail++;
              $display("FAIL m1_copy: got %h expected %h", act, e);
            end
          end
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    rst_n = 1'b0;
    v0 = 0; v1 = 0; dst0 = '0; dst1 = '0; dat0 = '0; dat1 = '0; al0 = '0; al1 = '0;
    #12;
    check("rst_busy0", 64'(busy0), 0);
    check("rst_busy1", 64'(busy1), 0);
    check("rst_ov", 64'({ov0, ov1}), 0);
    check("rst_starve", 64'({stv0, stv1}), 0);
    check("rst_req", 64'({req0, req1}), 0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    check("rst_ready", 64'({rdy0, rdy1}), 64'b11);

    // MODE1 partial: 0x10101, grant port 0 (+ an unrequested port 1), then ports 2 and 4
    v1 = 1; dst1 = 20'h10101; dat1 = 64'hA1A1_0000_0000_0001;
    tick();
    v1 = 0; al1 = 5'b00011; #1;
    check("m1_req_a", 64'(req1), 64'b10101);
    check("m1_busy_a", 64'(busy1), 1);
    check("m1_ready_a", 64'(rdy1), 0);
    push1(0, 20'h00001, 64'hA1A1_0000_0000_0001);
    tick();
    al1 = 5'b10100; #1;
    check("m1_req_b", 64'(req1), 64'b10100);
    check("m1_ready_b", 64'(rdy1), 1);
    push1(2, 20'h00100, 64'hA1A1_0000_0000_0001);
    push1(4, 20'h10000, 64'hA1A1_0000_0000_0001);
    tick();
    al1 = '0; #1;
    check("m1_busy_end", 64'(busy1), 0);
    check("m1_req_end", 64'(req1), 0);

    // MODE0 carry: single grant on port 2 takes the whole list
    v0 = 1; dst0 = 20'h10101; dat0 = 64'hB2B2_0000_0000_0002;
    tick();
    v0 = 0; al0 = 5'b00100; #1;
    check("m0_carry_ready", 64'(rdy0), 1);
    push0(2, 20'h10101, 64'hB2B2_0000_0000_0002);
    tick();
    al0 = '0; #1;
    check("m0_carry_busy", 64'(busy0), 0);

    // MODE0 fork plus back-to-back load in the release cycle
    v0 = 1; dst0 = 20'h10101; dat0 = 64'hC3C3_0000_0000_0003;
    tick();
    al0 = 5'b10001; v0 = 1; dst0 = 20'h02200; dat0 = 64'hD4D4_0000_0000_0004; #1;
    check("m0_fork_ready", 64'(rdy0), 1);
    push0(0, 20'h00101, 64'hC3C3_0000_0000_0003);
    push0(4, 20'h10000, 64'hC3C3_0000_0000_0003);
    tick();
    v0 = 0; al0 = '0; #1;
    check("m0_b2b_busy", 64'(busy0), 1);
    check("m0_b2b_req", 64'(req0), 64'b01100);
    tick();
    al0 = 5'b01000; #1;
    push0(3, 20'h02200, 64'hD4D4_0000_0000_0004);
    tick();
    al0 = '0; #1;
    check("m0_b2b_done", 64'(busy0), 0);

    // Starve: three zero-grant cycles (first one grants only an unrequested port)
    v0 = 1; dst0 = 20'h00010; dat0 = 64'hE5E5_0000_0000_0005;
    tick();
    v0 = 0; al0 = 5'b00001; #1;
    check("stv_0", 64'(stv0), 0);
    tick();
    al0 = '0; #1;
    check("stv_1", 64'(stv0), 0);
    tick();
    check("stv_2", 64'(stv0), 0);
    tick();
    check("stv_3", 64'(stv0), 1);
    check("stv_busy", 64'(busy0), 1);
    tick();
    check("stv_hold", 64'(stv0), 1);
    al0 = 5'b00010; #1;
    push0(1, 20'h00010, 64'hE5E5_0000_0000_0005);
    tick();
    al0 = '0; #1;
    check("stv_clear", 64'(stv0), 0);
    check("stv_busy_end", 64'(busy0), 0);

    // Zero destination list is dropped
    v0 = 1; dst0 = '0; dat0 = 64'hF6F6_0000_0000_0006;
    tick();
    v0 = 0; #1;
    check("drop_busy", 64'(busy0), 0);
    check("drop_req", 64'(req0), 0);

    // Grants while idle produce nothing (monitor flags any copy)
    al0 = '1; al1 = '1;
    tick(); tick();
    al0 = '0; al1 = '0; #1;
    check("idle_grant_busy", 64'({busy0, busy1}), 0);

    // Reset mid-HOLD with a copy just launched
    v1 = 1; dst1 = 20'h00011; dat1 = 64'h0707_0000_0000_0007;
    tick();
    v1 = 0; al1 = 5'b00001;
    @(negedge clk);
    check("mid_req", 64'(req1), 64'b00011);
    @(posedge clk);
    rst_n = 1'b0; al1 = '0; #1;
    check("mid_rst_busy", 64'(busy1), 0);
    check("mid_rst_ov", 64'(ov1), 0);
    check("mid_rst_starve", 64'(stv1), 0);
    check("mid_rst_req", 64'(req1), 0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    check("mid_rel_ready", 64'(rdy1), 1);
    check("mid_rel_busy", 64'(busy1), 0);

    tick(); tick();
    check("q0_drained", 64'(exp_q0.size()), 0);
    check("q1_drained", 64'(exp_q1.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
